// File: rtl/simplez_io_bus.sv
// SIMPLEZ bus responder: on-chip RAM in the low address space, with LED and buffered
// 8N1 UART transmitter registers in the top four words.
module simplez_io_bus #(
    parameter int unsigned DATAW    = 12,
    parameter int unsigned ADDRW    = 9,
    parameter int unsigned BAUD_DIV = 104
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADDRW-1:0] addr,
    input  logic             lec,
    input  logic             esc,
    input  logic [DATAW-1:0] wdata,
    output logic [DATAW-1:0] rdata,
    output logic [3:0]       leds,
    output logic             tx,
    output logic             tx_busy
);

    localparam int unsigned RamWords = (2 ** ADDRW) - 4;
    localparam int unsigned CntW     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    localparam logic [ADDRW-1:0] AddrLeds   = ADDRW'(RamWords);
    localparam logic [ADDRW-1:0] AddrTxData = ADDRW'(RamWords + 1);
    localparam logic [ADDRW-1:0] AddrTxStat = ADDRW'(RamWords + 2);
    localparam logic [CntW-1:0]  BaudLast   = CntW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic [DATAW-1:0] ram [RamWords];

    state_e           state_q, state_d;
    logic [CntW-1:0]  baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             ovr_q, ovr_d;
    logic [3:0]       leds_q;
    logic [DATAW-1:0] rdata_q;

    logic             is_ram;
    logic             rd_en;
    logic             wr_tx;
    logic             rd_stat;
    logic             load;
    logic             baud_last;
    logic             tx_c;
    logic [DATAW-1:0] rd_val;

    assign is_ram    = (addr < AddrLeds);
    assign rd_en     = lec && !esc;  // a write always wins a lec/esc collision
    assign wr_tx     = esc && (addr == AddrTxData);
    assign rd_stat   = rd_en && (addr == AddrTxStat);
    assign baud_last = (baud_q == BaudLast);

    always_comb begin
        rd_val = '0;
        if (is_ram) begin
            rd_val = ram[addr];
        end else if (addr == AddrLeds) begin
            rd_val = DATAW'(leds_q);
        end else if (addr == AddrTxStat) begin
            rd_val = DATAW'({ovr_q, tx_busy, ~hold_full_q});
        end
    end

    always_ff @(posedge clk) begin
        if (esc && is_ram) begin
            ram[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '1;
            leds_q  <= '0;
        end else begin
            if (rd_en) begin
                rdata_q <= rd_val;
            end
            if (esc && (addr == AddrLeds)) begin
                leds_q <= wdata[3:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        ovr_d       = ovr_q;
        load        = 1'b0;
        tx_c        = 1'b1;

        case (state_q)
            StIdle: begin
                if (hold_full_q) begin
                    load    = 1'b1;
                    baud_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                tx_c = 1'b0;
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                tx_c = shift_q[0];
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (hold_full_q) begin
                        load    = 1'b1;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
        end

        if (rd_stat) begin
            ovr_d = 1'b0;
        end

        // The holding slot being drained this same edge counts as free.
        if (wr_tx) begin
            if (!hold_full_q || load) begin
                hold_d      = wdata[7:0];
                hold_full_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ovr_q       <= ovr_d;
        end
    end

    assign rdata   = rdata_q;
    assign leds    = leds_q;
    assign tx      = tx_c;
    assign tx_busy = (state_q != StIdle);

endmodule

// File: tb/tb_simplez_io_bus.sv
// Directed bench for simplez_io_bus: table of single-cycle bus accesses, then hand-written
// UART frame, overrun and mid-frame reset sequences.
module tb_simplez_io_bus;

    localparam int BD = 104;

    logic        clk;
    logic        rst;
    logic [8:0]  addr;
    logic        lec;
    logic        esc;
    logic [11:0] wdata;
    logic [11:0] rdata;
    logic [3:0]  leds;
    logic        tx;
    logic        tx_busy;

    int n_checks = 0;
    int n_fail   = 0;

    simplez_io_bus #(
        .DATAW    (12),
        .ADDRW    (9),
        .BAUD_DIV (BD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .lec     (lec),
        .esc     (esc),
        .wdata   (wdata),
        .rdata   (rdata),
        .leds    (leds),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        lec;
        logic        esc;
        logic [8:0]  addr;
        logic [11:0] wdata;
        logic [11:0] exp_rdata;
        logic [3:0]  exp_leds;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic l, input logic e, input logic [8:0] a, input logic [11:0] d);
        lec   = l;
        esc   = e;
        addr  = a;
        wdata = d;
        tick();
        lec = 1'b0;
        esc = 1'b0;
    endtask

    // Checks one whole 8N1 frame, starting 'skip' cycles after the start bit began.
    task automatic check_frame(input logic [7:0] b, input int skip);
        logic [9:0] bits;
        int         bad;
        logic       got_tx;
        logic       got_busy;
        bits     = {1'b1, b, 1'b0};
        bad      = 0;
        got_tx   = 1'b1;
        got_busy = 1'b1;
        for (int i = skip; i < 10 * BD; i++) begin
            if (tx !== bits[i / BD] || tx_busy !== 1'b1) begin
                bad++;
                got_tx   = tx;
                got_busy = tx_busy;
            end
            if (i % BD == BD - 1) begin
                n_checks++;
                if (bad != 0) begin
                    n_fail++;
                    $display("FAIL frame %02h bit %0d: %0d bad cycles, tx=%b busy=%b, required tx=%b busy=1",
                             b, i / BD, bad, got_tx, got_busy, bits[i / BD]);
                end
                bad = 0;
            end
            tick();
        end
    endtask

    initial begin
        int bad;

        vecs[0]  = '{1'b1, 1'b0, 9'd508, 12'h000, 12'h000, 4'h0};
        vecs[1]  = '{1'b1, 1'b0, 9'd510, 12'h000, 12'h001, 4'h0};
        vecs[2]  = '{1'b1, 1'b0, 9'd511, 12'h000, 12'h000, 4'h0};
        vecs[3]  = '{1'b0, 1'b1, 9'd3,   12'hA5C, 12'h000, 4'h0};
        vecs[4]  = '{1'b1, 1'b0, 9'd3,   12'h000, 12'hA5C, 4'h0};
        vecs[5]  = '{1'b0, 1'b1, 9'd508, 12'h00F, 12'hA5C, 4'hF};
        vecs[6]  = '{1'b1, 1'b0, 9'd508, 12'h000, 12'h00F, 4'hF};
        vecs[7]  = '{1'b0, 1'b1, 9'd508, 12'hFF3, 12'h00F, 4'h3};
        vecs[8]  = '{1'b1, 1'b0, 9'd508, 12'h000, 12'h003, 4'h3};
        vecs[9]  = '{1'b0, 1'b1, 9'd511, 12'h123, 12'h003, 4'h3};
        vecs[10] = '{1'b1, 1'b0, 9'd511, 12'h000, 12'h000, 4'h3};
        vecs[11] = '{1'b0, 1'b1, 9'd510, 12'hFFF, 12'h000, 4'h3};
        vecs[12] = '{1'b1, 1'b0, 9'd510, 12'h000, 12'h001, 4'h3};
        vecs[13] = '{1'b0, 1'b1, 9'd0,   12'h111, 12'h001, 4'h3};
        vecs[14] = '{1'b0, 1'b1, 9'd507, 12'h222, 12'h001, 4'h3};
        vecs[15] = '{1'b1, 1'b0, 9'd507, 12'h000, 12'h222, 4'h3};
        vecs[16] = '{1'b1, 1'b0, 9'd0,   12'h000, 12'h111, 4'h3};
        vecs[17] = '{1'b1, 1'b1, 9'd7,   12'h777, 12'h111, 4'h3};
        vecs[18] = '{1'b1, 1'b0, 9'd7,   12'h000, 12'h777, 4'h3};
        vecs[19] = '{1'b0, 1'b0, 9'd7,   12'h000, 12'h777, 4'h3};
        vecs[20] = '{1'b1, 1'b0, 9'd509, 12'h000, 12'h000, 4'h3};

        rst   = 1'b1;
        lec   = 1'b0;
        esc   = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset rdata", rdata, 12'hFFF);
        check("reset leds", leds, 4'h0);
        check("reset tx", tx, 1'b1);
        check("reset tx_busy", tx_busy, 1'b0);

        for (int i = 0; i < 21; i++) begin
            bus(vecs[i].lec, vecs[i].esc, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d leds", i), leds, vecs[i].exp_leds);
            check($sformatf("vec%0d tx idle", i), tx, 1'b1);
        end

        // Single frame of 0x55
        bus(1'b0, 1'b1, 9'd509, 12'h055);
        check("queued tx still idle", tx, 1'b1);
        tick();
        check_frame(8'h55, 0);
        check("after frame tx", tx, 1'b1);
        check("after frame busy", tx_busy, 1'b0);
        bus(1'b1, 1'b0, 9'd510, 12'h000);
        check("stat after frame", rdata, 12'h001);

        // Three back-to-back writes: first two sent, third overruns
        bus(1'b0, 1'b1, 9'd509, 12'h041);
        bus(1'b0, 1'b1, 9'd509, 12'h042);
        bus(1'b0, 1'b1, 9'd509, 12'h043);
        bus(1'b1, 1'b0, 9'd510, 12'h000);
        check("stat overrun", rdata, 12'h006);
        bus(1'b1, 1'b0, 9'd510, 12'h000);
        check("stat ovr cleared", rdata, 12'h002);
        check_frame(8'h41, 3);
        check_frame(8'h42, 0);
        check("after pair tx", tx, 1'b1);
        check("after pair busy", tx_busy, 1'b0);

        // Reset during data bit 4, with a second byte waiting in the holding slot
        bus(1'b0, 1'b1, 9'd509, 12'h0EF);
        bus(1'b0, 1'b1, 9'd509, 12'h033);
        repeat (5 * BD) @(posedge clk);
        #1;
        check("mid-frame bit4 tx", tx, 1'b0);
        check("mid-frame busy", tx_busy, 1'b1);
        rst = 1'b1;
        tick();
        check("rst tx", tx, 1'b1);
        check("rst busy", tx_busy, 1'b0);
        check("rst rdata", rdata, 12'hFFF);
        rst = 1'b0;
        bus(1'b1, 1'b0, 9'd510, 12'h000);
        check("stat after rst", rdata, 12'h001);
        bad = 0;
        for (int i = 0; i < 2 * BD; i++) begin
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
            tick();
        end
        check("idle after rst (bad cycles)", bad, 0);

        bus(1'b1, 1'b1, 9'd7, 12'h7E7);
        check("lec&esc rdata held", rdata, 12'h001);
        bus(1'b1, 1'b0, 9'd7, 12'h000);
        check("lec&esc write landed", rdata, 12'h7E7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
